fir_coeff_loader: RTL and testbench

- Drives the serial coefficient-load port of the symmetric FIR filter from a host-writable coefficient bank.
- The host writes coefficients by address, then pulses `start`.
- The block then clears the filter, streams the bank onto `load`/`coeff_value` in index order, and issues the terminating load cycle that latches the filter's "coefficients loaded" state.
- It sits between the control/host logic and the filter, as the transmitter end of the coefficient interface.

---
 rtl/fir_coeff_loader.sv | 146 ++++++++++++++
 tb/tb_fir_coeff_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: host-writable coefficient bank that drives the serial
// coefficient-load port of the symmetric FIR filter.
// After start it clears the filter, streams bank[0..COEFF_NUM-1] and then
// issues one terminating load cycle with a zero value.
// Handshake: no valid/ready pair. A host write is accepted when wr_en=1,
// busy=0 and wr_addr<COEFF_NUM. A rejected write pulses wr_err in the next
// cycle. start is honoured only in IDLE/DONE; while busy it is dropped.
// Every output is registered and decoded from the next state, so each one
// reflects the current state with no input-to-output combinational path.
// dbg_state exposes the FSM state register.
module fir_coeff_loader #(
   parameter int COEFF_NUM   = 6,
   parameter int COEFF_WIDTH = 8,
   parameter int ADDR_WIDTH  = $clog2(COEFF_NUM)
) (
   input  logic                          clk,
   input  logic                          clr,
   input  logic                          wr_en,
   input  logic [ADDR_WIDTH-1:0]         wr_addr,
   input  logic signed [COEFF_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0]         rd_addr,
   output logic signed [COEFF_WIDTH-1:0] rd_data,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          wr_err,
   output logic                          fir_clr,
   output logic                          load,
   output logic signed [COEFF_WIDTH-1:0] coeff_value,
   output logic [2:0]                    dbg_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      STREAM = 3'd2,
      TERM   = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(COEFF_NUM - 1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   k_q, k_d;
   logic [COEFF_WIDTH-1:0]  bank_q [COEFF_NUM];
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    wr_err_q, wr_err_d;
   logic                    fir_clr_q, fir_clr_d;
   logic                    load_q, load_d;
   logic [COEFF_WIDTH-1:0]  coeff_q, coeff_d;
   logic [COEFF_WIDTH-1:0]  rd_q, rd_d;
   logic [COEFF_WIDTH-1:0]  coeff_sel;
   logic                    wr_accept;

   // Write acceptance uses the registered busy flag, i.e. the current state.
   always_comb begin
      wr_accept = wr_en && !busy_q && (32'(wr_addr) < COEFF_NUM);
   end

   // Coefficient bank: cleared by reset, written only on an accepted write.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < COEFF_NUM; i++) bank_q[i] <= '0;
      end else begin
         for (int i = 0; i < COEFF_NUM; i++) begin
            if (wr_accept && (wr_addr == ADDR_WIDTH'(i))) bank_q[i] <= wr_data;
         end
      end
   end

   // FSM and output registers.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= IDLE;
         k_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_err_q  <= 1'b0;
         fir_clr_q <= 1'b0;
         load_q    <= 1'b0;
         coeff_q   <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_err_q  <= wr_err_d;
         fir_clr_q <= fir_clr_d;
         load_q    <= load_d;
         coeff_q   <= coeff_d;
         rd_q      <= rd_d;
      end
   end

   // Next state and stream index; k_q is the index presented while in STREAM.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         IDLE:   if (start) state_d = CLEAR;
         CLEAR: begin
            state_d = STREAM;
            k_d     = '0;
         end
         STREAM: begin
            if (k_q == K_LAST) state_d = TERM;
            else               k_d     = k_q + ADDR_WIDTH'(1);
         end
         TERM:   state_d = DONE;
         // start wins over a simultaneous write; the write still lands first.
         DONE: begin
            if (start)          state_d = CLEAR;
            else if (wr_accept) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the next state so registered outputs track state_q.
   always_comb begin
      coeff_sel = '0;
      rd_d      = '0;
      for (int i = 0; i < COEFF_NUM; i++) begin
         if (k_d == ADDR_WIDTH'(i))     coeff_sel = bank_q[i];
         if (rd_addr == ADDR_WIDTH'(i)) rd_d      = bank_q[i];
      end
      busy_d    = (state_d == CLEAR) || (state_d == STREAM) || (state_d == TERM);
      done_d    = (state_d == DONE);
      fir_clr_d = (state_d == CLEAR);
      load_d    = (state_d == STREAM) || (state_d == TERM);
      coeff_d   = (state_d == STREAM) ? coeff_sel : '0;
      wr_err_d  = wr_en && !wr_accept;
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign wr_err      = wr_err_q;
   assign fir_clr     = fir_clr_q;
   assign load        = load_q;
   assign coeff_value = coeff_q;
   assign rd_data     = rd_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Testbench for fir_coeff_loader: directed vectors, load-stream scoreboard,
// cycle-exact timing checks against the start cycle.
module tb_fir_coeff_loader;

   localparam int N  = 6;
   localparam int W  = 8;
   localparam int AW = 3;

   logic                clk = 1'b0;
   logic                clr;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic signed [W-1:0] wr_data;
   logic [AW-1:0]       rd_addr;
   logic signed [W-1:0] rd_data;
   logic                start;
   logic                busy;
   logic                done;
   logic                wr_err;
   logic                fir_clr;
   logic                load;
   logic signed [W-1:0] coeff_value;
   logic [2:0]          dbg_state;

   int                  n_checks = 0;
   int                  n_fail   = 0;
   logic [W-1:0]        exp_q[$];
   logic [W-1:0]        model [N];
   int                  flt_cnt;
   logic                flt_loaded;

   fir_coeff_loader #(.COEFF_NUM(N), .COEFF_WIDTH(W)) dut (
      .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .busy(busy),
      .done(done), .wr_err(wr_err), .fir_clr(fir_clr), .load(load),
      .coeff_value(coeff_value), .dbg_state(dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   // Minimal filter-side model: counts coefficient loads, latches "loaded"
   // on the terminating load after COEFF_NUM coefficients.
   always @(posedge clk or posedge clr) begin
      if (clr) begin
         flt_cnt    <= 0;
         flt_loaded <= 1'b0;
      end else if (fir_clr) begin
         flt_cnt    <= 0;
         flt_loaded <= 1'b0;
      end else if (load) begin
         if (flt_cnt == N) flt_loaded <= 1'b1;
         else              flt_cnt    <= flt_cnt + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every load cycle pops one expected coefficient.
   always @(negedge clk) begin
      if (!clr && load) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_stream: unexpected load with coeff_value=%0h, expected no load",
                     $unsigned(coeff_value));
         end else begin
            check("load_stream", $unsigned(coeff_value), exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_stream();
      for (int i = 0; i < N; i++) exp_q.push_back(model[i]);
      exp_q.push_back('0);
   endtask

   task automatic read_check(input logic [AW-1:0] a, input logic [W-1:0] exp);
      rd_addr = a;
      tick();
      check($sformatf("rd_data[%0d]", a), $unsigned(rd_data), exp);
   endtask

   task automatic write_bank(input logic [AW-1:0] a, input logic [W-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   // Full sequence from start. With poke set: a write at S+4 (rejected) and
   // start pulses at S+6 and S+8 (ignored).
   task automatic run_seq(input bit poke);
      start = 1'b1;
      push_stream();
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      check("s1_fir_clr", fir_clr, 1);
      check("s1_busy", busy, 1);
      check("s1_load", load, 0);
      check("s1_done", done, 0);
      for (int c = 2; c <= 2 + N; c++) begin
         tick();
         check($sformatf("s%0d_load", c), load, 1);
         check($sformatf("s%0d_busy", c), busy, 1);
         check($sformatf("s%0d_fir_clr", c), fir_clr, 0);
         if (poke) begin
            case (c)
               4: begin
                  wr_en   = 1'b1;
                  wr_addr = 3'd2;
                  wr_data = 8'sh33;
               end
               5: begin
                  check("busy_wr_err", wr_err, 1);
                  wr_en = 1'b0;
               end
               6: begin
                  check("busy_wr_err_clear", wr_err, 0);
                  start = 1'b1;
               end
               7: start = 1'b0;
               8: start = 1'b1;
               default: ;
            endcase
         end
      end
      tick();
      start = 1'b0;
      check("s9_done", done, 1);
      check("s9_busy", busy, 0);
      check("s9_load", load, 0);
      check("s9_coeff", $unsigned(coeff_value), 0);
      check("s9_filter_loaded", flt_loaded, 1);
      tick();
      check("s10_done_held", done, 1);
      check("s10_no_restart", fir_clr, 0);
   endtask

   initial begin
      logic [W-1:0] vals [N];
      vals = '{8'h11, 8'hF0, 8'h05, 8'h80, 8'h7F, 8'h01};
      clr     = 1'b1;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      start   = 1'b0;
      for (int i = 0; i < N; i++) model[i] = '0;
      repeat (3) tick();

      // Reset values.
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_err", wr_err, 0);
      check("rst_fir_clr", fir_clr, 0);
      check("rst_load", load, 0);
      check("rst_coeff", $unsigned(coeff_value), 0);
      check("rst_rd_data", $unsigned(rd_data), 0);
      check("rst_state", dbg_state, 0);
      clr = 1'b0;
      for (int a = 0; a < N; a++) read_check(AW'(a), 8'h00);

      // Write and read back.
      for (int i = 0; i < N; i++) begin
         model[i] = vals[i];
         write_bank(AW'(i), vals[i]);
         check("wr_ok_no_err", wr_err, 0);
      end
      for (int a = 0; a < N; a++) read_check(AW'(a), vals[a]);

      // Full sequence with a rejected busy write and ignored starts.
      run_seq(1'b1);
      read_check(3'd2, 8'h05);

      // Out-of-range write in DONE: rejected, done stays.
      write_bank(3'd6, 8'h5A);
      check("oor_wr_err", wr_err, 1);
      check("oor_done_kept", done, 1);
      tick();
      check("oor_wr_err_clear", wr_err, 0);
      read_check(3'd6, 8'h00);
      read_check(3'd7, 8'h00);
      for (int a = 0; a < N; a++) read_check(AW'(a), model[a]);

      // Valid write in DONE: bank is stale, done drops.
      model[3] = 8'h22;
      write_bank(3'd3, 8'h22);
      check("stale_done_drop", done, 0);
      check("stale_no_err", wr_err, 0);
      check("stale_state_idle", dbg_state, 0);

      // Write and start in the same cycle: new value must be streamed.
      model[5] = 8'hAA;
      wr_en    = 1'b1;
      wr_addr  = 3'd5;
      wr_data  = 8'shAA;
      run_seq(1'b0);
      read_check(3'd3, 8'h22);
      read_check(3'd5, 8'hAA);

      // Mid-sequence reset at S+5.
      start = 1'b1;
      push_stream();
      tick();
      start = 1'b0;
      repeat (4) tick();
      clr = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_load", load, 0);
      check("midrst_fir_clr", fir_clr, 0);
      check("midrst_coeff", $unsigned(coeff_value), 0);
      check("midrst_state", dbg_state, 0);
      tick();
      clr = 1'b0;
      for (int i = 0; i < N; i++) model[i] = '0;
      for (int a = 0; a < N; a++) read_check(AW'(a), 8'h00);
      check("midrst_idle_after", dbg_state, 0);
      check("midrst_no_done", done, 0);

      check("exp_q_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
